// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for the sequential restoring divider.
// The master drives operands and start; the slave returns status and results.
interface seq_divider_if #(
  parameter int N_WIDTH = 16,
  parameter int D_WIDTH = 8
);
  logic               start;
  logic [N_WIDTH-1:0] dividend;
  logic [D_WIDTH-1:0] divisor;
  logic               busy;
  logic               done;
  logic [N_WIDTH-1:0] quotient;
  logic [D_WIDTH-1:0] remainder;
  logic               div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock via ripple trial-subtract.
// A zero divisor is answered on the accept edge with an all-ones quotient and a flag.
module seq_divider #(
  parameter int N_WIDTH = 16,
  parameter int D_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus_if
);

  localparam int CNT_W = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [N_WIDTH-1:0] dvd_q, dvd_d;
  logic [D_WIDTH-1:0] dvs_q, dvs_d;
  logic [D_WIDTH:0]   prem_q, prem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_WIDTH-1:0] quo_q, quo_d;
  logic [D_WIDTH-1:0] rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [D_WIDTH:0]   shift_rem;
  logic [D_WIDTH+1:0] sub_res;
  logic               trial_neg;

  // Ripple-borrow subtractor; MSB of the result is the borrow out (negative result).
  function automatic logic [D_WIDTH+1:0] ripple_sub(input logic [D_WIDTH:0] a,
                                                    input logic [D_WIDTH:0] b);
    logic [D_WIDTH:0] diff;
    logic             borrow;
    diff   = {(D_WIDTH+1){1'b0}};
    borrow = 1'b0;
    for (int i = 0; i <= D_WIDTH; i++) begin
      diff[i] = a[i] ^ b[i] ^ borrow;
      borrow  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow);
    end
    return {borrow, diff};
  endfunction

  // Next-state, datapath step and result capture.
  always_comb begin
    shift_rem = {prem_q[D_WIDTH-1:0], dvd_q[N_WIDTH-1]};
    sub_res   = ripple_sub(shift_rem, {1'b0, dvs_q});
    trial_neg = sub_res[D_WIDTH+1];
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_if.start) begin
          if (bus_if.divisor != {D_WIDTH{1'b0}}) begin
            dvd_d   = bus_if.dividend;
            dvs_d   = bus_if.divisor;
            prem_d  = {(D_WIDTH+1){1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            quo_d  = {N_WIDTH{1'b1}};
            rem_d  = bus_if.dividend[D_WIDTH-1:0];
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      RUN: begin
        // Restore on borrow by keeping the unsubtracted shifted remainder.
        prem_d = trial_neg ? shift_rem : sub_res[D_WIDTH:0];
        dvd_d  = {dvd_q[N_WIDTH-2:0], ~trial_neg};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_WIDTH - 1)) begin
          quo_d   = {dvd_q[N_WIDTH-2:0], ~trial_neg};
          rem_d   = prem_d[D_WIDTH-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= {N_WIDTH{1'b0}};
      dvs_q   <= {D_WIDTH{1'b0}};
      prem_q  <= {(D_WIDTH+1){1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      quo_q   <= {N_WIDTH{1'b0}};
      rem_q   <= {D_WIDTH{1'b0}};
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus_if.busy        = busy_q;
  assign bus_if.done        = done_q;
  assign bus_if.quotient    = quo_q;
  assign bus_if.remainder   = rem_q;
  assign bus_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider: latency, handshake, zero divisor, reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seq_divider;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  seq_divider_if #(.N_WIDTH(16), .D_WIDTH(8)) u_if ();

  seq_divider #(.N_WIDTH(16), .D_WIDTH(8)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands at the current falling edge, drop start at the next one.
  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    u_if.start    = 1'b1;
    u_if.dividend = a;
    u_if.divisor  = b;
    @(negedge clk);
    u_if.start    = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc     = 0;
    busy_ok = 1'b1;
    while (u_if.done !== 1'b1 && cyc < 40) begin
      if (u_if.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (u_if.done !== 1'b1) check_eq("done_timeout", {31'd0, u_if.done}, 32'd1);
  endtask

  task automatic expect_result(input string tag, input logic [15:0] q, input logic [7:0] r,
                               input int lat);
    int cyc;
    bit bok;
    wait_done(cyc, bok);
    check_eq({tag, "_lat"}, cyc, lat);
    check_eq({tag, "_busy"}, {31'd0, bok}, 32'd1);
    check_eq({tag, "_q"}, {16'd0, u_if.quotient}, {16'd0, q});
    check_eq({tag, "_r"}, {24'd0, u_if.remainder}, {24'd0, r});
    check_eq({tag, "_dbz"}, {31'd0, u_if.div_by_zero}, 32'd0);
  endtask

  initial begin
    int          cyc;
    bit          bok;
    logic [15:0] a;
    logic [7:0]  b;
    errs          = 0;
    checks        = 0;
    rst_n         = 1'b0;
    u_if.start    = 1'b0;
    u_if.dividend = 16'd0;
    u_if.divisor  = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, u_if.busy}, 32'd0);
    check_eq("rst_done", {31'd0, u_if.done}, 32'd0);
    check_eq("rst_q", {16'd0, u_if.quotient}, 32'd0);
    check_eq("rst_r", {24'd0, u_if.remainder}, 32'd0);
    check_eq("rst_dbz", {31'd0, u_if.div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(16'd1000, 8'd7);
    expect_result("d1000_7", 16'd142, 8'd6, 16);
    @(negedge clk);
    check_eq("done_pulse", {31'd0, u_if.done}, 32'd0);

    // Back-to-back: each new start is presented during the done cycle.
    launch(16'd65535, 8'd1);
    expect_result("d65535_1", 16'd65535, 8'd0, 16);
    launch(16'd65535, 8'd255);
    expect_result("d65535_255", 16'd257, 8'd0, 16);
    launch(16'd5, 8'd9);
    expect_result("d5_9", 16'd0, 8'd5, 16);
    @(negedge clk);

    launch(16'd1234, 8'd0);
    check_eq("dz_done", {31'd0, u_if.done}, 32'd1);
    check_eq("dz_busy", {31'd0, u_if.busy}, 32'd0);
    check_eq("dz_q", {16'd0, u_if.quotient}, 32'h0000FFFF);
    check_eq("dz_r", {24'd0, u_if.remainder}, 32'h000000D2);
    check_eq("dz_flag", {31'd0, u_if.div_by_zero}, 32'd1);
    @(negedge clk);
    check_eq("dz_pulse", {31'd0, u_if.done}, 32'd0);
    check_eq("dz_hold", {31'd0, u_if.div_by_zero}, 32'd1);
    launch(16'd10, 8'd3);
    expect_result("d10_3", 16'd3, 8'd1, 16);
    @(negedge clk);

    // Start while busy must be ignored.
    launch(16'd5000, 8'd13);
    repeat (4) @(negedge clk);
    u_if.start    = 1'b1;
    u_if.dividend = 16'd9;
    u_if.divisor  = 8'd2;
    @(negedge clk);
    u_if.start = 1'b0;
    wait_done(cyc, bok);
    check_eq("ign_lat", cyc + 5, 16);
    check_eq("ign_q", {16'd0, u_if.quotient}, 32'd384);
    check_eq("ign_r", {24'd0, u_if.remainder}, 32'd8);
    @(negedge clk);

    // Asynchronous reset in the middle of a division.
    launch(16'd40000, 8'd200);
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", {31'd0, u_if.busy}, 32'd0);
    check_eq("arst_done", {31'd0, u_if.done}, 32'd0);
    check_eq("arst_q", {16'd0, u_if.quotient}, 32'd0);
    check_eq("arst_r", {24'd0, u_if.remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(16'd40000, 8'd200);
    expect_result("d40000_200", 16'd200, 8'd0, 16);
    @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 8'($urandom_range(1, 255));
      launch(a, b);
      wait_done(cyc, bok);
      check_eq("rnd_q", {16'd0, u_if.quotient}, {16'd0, a / {8'd0, b}});
      check_eq("rnd_r", {24'd0, u_if.remainder}, {24'd0, 8'(a % {8'd0, b})});
      check_eq("rnd_lt", {31'd0, (u_if.remainder < b)}, 32'd1);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
